// File: rtl/btn_pkg.sv
// Shared state/event encodings for the front-panel button controller.
// REPEAT_BUILT mirrors the BTN_REPEAT_EN build option.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } btn_state_e;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_REPEAT  = 2'd2
    } evt_kind_e;

`ifdef BTN_REPEAT_EN
    localparam bit REPEAT_BUILT = 1'b1;
`else
    localparam bit REPEAT_BUILT = 1'b0;
`endif

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: synchroniser, majority window filter, press/release FSM and pending slot.
// Auto-repeat state and hold counter exist only when BTN_REPEAT_EN is defined.
module btn_channel
    import btn_pkg::*;
#(
    parameter int WINDOW       = 16,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    input  logic       tick,
    input  logic       grant,
    output logic       level,
    output logic       slot_valid,
    output logic [1:0] slot_kind,
    output logic       drop
);

    localparam int CW = cnt_width(WINDOW);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] samp_q, samp_d, ones_q, ones_d, ones_new;
    logic          level_q, level_d;
    btn_state_e    state_q, state_d;
    logic          slot_v_q, slot_v_d;
    logic [1:0]    slot_kind_q, slot_kind_d;
    logic          post;
    logic [1:0]    post_kind;

`ifdef BTN_REPEAT_EN
    localparam int HW = cnt_width((HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS);
    logic [HW-1:0] hold_q, hold_d, hold_inc;
    assign hold_inc = hold_q + 1'b1;
`endif

    assign ones_new = ones_q + CW'(sync2_q);

    always_comb begin
        samp_d  = samp_q;
        ones_d  = ones_q;
        level_d = level_q;
        if (tick) begin
            if (samp_q == CW'(WINDOW - 1)) begin
                // 2*ones >= WINDOW, so a tie resolves to pressed
                level_d = ({ones_new, 1'b0} >= (CW + 1)'(WINDOW));
                samp_d  = '0;
                ones_d  = '0;
            end else begin
                samp_d = samp_q + 1'b1;
                ones_d = ones_new;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        post      = 1'b0;
        post_kind = EVT_PRESS;
`ifdef BTN_REPEAT_EN
        hold_d    = hold_q;
`endif
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (level_d) begin
                        state_d   = PRESSED;
                        post      = 1'b1;
                        post_kind = EVT_PRESS;
`ifdef BTN_REPEAT_EN
                        hold_d    = '0;
`endif
                    end
                end
                PRESSED: begin
                    if (!level_d) begin
                        state_d   = IDLE;
                        post      = 1'b1;
                        post_kind = EVT_RELEASE;
                    end
`ifdef BTN_REPEAT_EN
                    else if (hold_inc == HW'(HOLD_TICKS)) begin
                        state_d   = REPEAT;
                        hold_d    = '0;
                        post      = 1'b1;
                        post_kind = EVT_REPEAT;
                    end else begin
                        hold_d = hold_inc;
                    end
`endif
                end
`ifdef BTN_REPEAT_EN
                REPEAT: begin
                    if (!level_d) begin
                        state_d   = IDLE;
                        post      = 1'b1;
                        post_kind = EVT_RELEASE;
                    end else if (hold_inc == HW'(REPEAT_TICKS)) begin
                        hold_d    = '0;
                        post      = 1'b1;
                        post_kind = EVT_REPEAT;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // A slot being granted this cycle is free again, so a post lands instead of dropping.
    always_comb begin
        drop        = 1'b0;
        slot_v_d    = slot_v_q;
        slot_kind_d = slot_kind_q;
        if (grant) begin
            slot_v_d = 1'b0;
        end
        if (post) begin
            if (slot_v_q && !grant) begin
                drop = 1'b1;
            end else begin
                slot_v_d    = 1'b1;
                slot_kind_d = post_kind;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            samp_q      <= '0;
            ones_q      <= '0;
            level_q     <= 1'b0;
            state_q     <= IDLE;
            slot_v_q    <= 1'b0;
            slot_kind_q <= EVT_PRESS;
`ifdef BTN_REPEAT_EN
            hold_q      <= '0;
`endif
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            samp_q      <= samp_d;
            ones_q      <= ones_d;
            level_q     <= level_d;
            state_q     <= state_d;
            slot_v_q    <= slot_v_d;
            slot_kind_q <= slot_kind_d;
`ifdef BTN_REPEAT_EN
            hold_q      <= hold_d;
`endif
        end
    end

    assign level      = level_q;
    assign slot_valid = slot_v_q;
    assign slot_kind  = slot_kind_q;

endmodule

// File: rtl/button_ctrl.sv
// Button controller top: sample prescaler, per-button channels, round-robin event arbiter.
// Auto-repeat events are built only when BTN_REPEAT_EN is defined.
module button_ctrl
    import btn_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int SAMPLE_DIV   = 50000,
    parameter int WINDOW       = 16,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100,
    localparam int ID_W        = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             enable,
    input  logic             evt_ready,
    input  logic             clr_drop,
    output logic [N_BTN-1:0] level,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    output logic [1:0]       evt_kind,
    output logic             dropped
);

    localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [PW-1:0]   presc_q, presc_d;
    logic            tick;
    logic [N_BTN-1:0] slot_valid, grant, drop;
    logic [1:0]      slot_kind [N_BTN];
    logic            evt_valid_q, evt_valid_d;
    logic [ID_W-1:0] evt_id_q, evt_id_d;
    logic [1:0]      evt_kind_q, evt_kind_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            dropped_q, dropped_d;
    logic            load, found;
    logic [ID_W-1:0] pick;
    int              idx;

    assign tick = enable && (presc_q == PW'(SAMPLE_DIV - 1));

    always_comb begin
        presc_d = presc_q + 1'b1;
        if (!enable || tick) begin
            presc_d = '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_ch
            btn_channel #(
                .WINDOW      (WINDOW),
                .HOLD_TICKS  (HOLD_TICKS),
                .REPEAT_TICKS(REPEAT_TICKS)
            ) u_ch (
                .clk       (clk),
                .rst_n     (rst_n),
                .btn_raw   (btn_in[gi]),
                .tick      (tick),
                .grant     (grant[gi]),
                .level     (level[gi]),
                .slot_valid(slot_valid[gi]),
                .slot_kind (slot_kind[gi]),
                .drop      (drop[gi])
            );
            assign grant[gi] = load && found && (pick == ID_W'(gi));
        end
    endgenerate

    assign load = !evt_valid_q || evt_ready;

    // Scan from the far end back to the pointer so the nearest valid slot wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_BTN) begin
                idx = idx - N_BTN;
            end
            if (slot_valid[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        evt_kind_d  = evt_kind_q;
        ptr_d       = ptr_q;
        if (load) begin
            evt_valid_d = found;
            if (found) begin
                evt_id_d   = pick;
                evt_kind_d = slot_kind[pick];
                ptr_d      = (pick == ID_W'(N_BTN - 1)) ? '0 : pick + 1'b1;
            end
        end
        dropped_d = dropped_q;
        if (|drop) begin
            dropped_d = 1'b1;
        end else if (clr_drop) begin
            dropped_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_kind_q  <= '0;
            ptr_q       <= '0;
            dropped_q   <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            evt_kind_q  <= evt_kind_d;
            ptr_q       <= ptr_d;
            dropped_q   <= dropped_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign evt_kind  = evt_kind_q;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_button_ctrl.sv
// Directed bench for button_ctrl: N_BTN=4, SAMPLE_DIV=4, WINDOW=4, HOLD_TICKS=3, REPEAT_TICKS=2.
// Expectations track btn_pkg::REPEAT_BUILT so they follow however BTN_REPEAT_EN was set.
`ifndef BTN_REPEAT_EN
`define BTN_REPEAT_EN
`endif
module tb_button_ctrl;
    import btn_pkg::*;

    localparam int N_BTN   = 4;
    localparam int SD      = 4;
    localparam int W       = 4;
    localparam int WIN_CYC = SD * W;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic [N_BTN-1:0] btn_in    = '0;
    logic             enable    = 1'b0;
    logic             evt_ready = 1'b0;
    logic             clr_drop  = 1'b0;
    logic [N_BTN-1:0] level;
    logic             evt_valid;
    logic [1:0]       evt_id;
    logic [1:0]       evt_kind;
    logic             dropped;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;

    typedef struct {
        int id;
        int kind;
        int t;
    } ev_t;
    ev_t evq[$];

    button_ctrl #(
        .N_BTN       (N_BTN),
        .SAMPLE_DIV  (SD),
        .WINDOW      (W),
        .HOLD_TICKS  (3),
        .REPEAT_TICKS(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_in   (btn_in),
        .enable   (enable),
        .evt_ready(evt_ready),
        .clr_drop (clr_drop),
        .level    (level),
        .evt_valid(evt_valid),
        .evt_id   (evt_id),
        .evt_kind (evt_kind),
        .dropped  (dropped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Record every completed handshake.
    always @(negedge clk) begin
        if (rst_n && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            evq.push_back('{id: int'(evt_id), kind: int'(evt_kind), t: cyc_cnt});
            $display("evt id=%0d kind=%0d cycle=%0d", evt_id, evt_kind, cyc_cnt);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_level(input logic [N_BTN-1:0] mask, input logic [N_BTN-1:0] val,
                              input int budget, input string tag);
        int n = 0;
        while (((level & mask) !== val) && n < budget) begin
            cyc(1);
            n++;
        end
        check(tag, level & mask, val);
    endtask

    function automatic int count_ev(input int id, input int kind);
        int c = 0;
        foreach (evq[k]) if (evq[k].id == id && evq[k].kind == kind) c++;
        return c;
    endfunction

    function automatic int last_idx();
        return (evq.size() > 0) ? evq.size() - 1 : 0;
    endfunction

    initial begin
        int nrep;
        int n0;

        // Reset state
        cyc(2);
        check("rst_valid", evt_valid, 0);
        check("rst_level", level, 0);
        check("rst_dropped", dropped, 0);
        check("rst_id", evt_id, 0);
        check("rst_kind", evt_kind, 0);

        // Tie window on btn2: samples 1,0,1,0 then 0,0,0,0 then 1,0,0,0
        rst_n = 1'b1; enable = 1'b1; evt_ready = 1'b1; btn_in = 4'b0100;
        evq.delete();
        cyc(4); btn_in[2] = 1'b0;
        cyc(4); btn_in[2] = 1'b1;
        cyc(4); btn_in[2] = 1'b0;
        cyc(3);
        check("tie_early", level[2], 0);
        cyc(1);
        check("tie_level", level[2], 1);
        cyc(16);
        check("tie_fall", level[2], 0);
        btn_in[2] = 1'b1;
        cyc(4); btn_in[2] = 1'b0;
        cyc(12);
        check("one_of_four", level[2], 0);
        cyc(4);
        check("tie_nev", evq.size(), 2 + int'(REPEAT_BUILT));
        check("tie_first_id", evq[0].id, 2);
        check("tie_first_kind", evq[0].kind, EVT_PRESS);
        check("tie_last_kind", evq[last_idx()].kind, EVT_RELEASE);
        check("tie_rpt", count_ev(2, EVT_REPEAT), int'(REPEAT_BUILT));

        // Mid-operation reset with an event presented and the pointer away from 0
        evt_ready = 1'b0; btn_in = 4'b0010;
        wait_level(4'b0010, 4'b0010, 40, "t1_lvl");
        cyc(2);
        check("t1_valid", evt_valid, 1);
        check("t1_id_ptr", evt_id, 1);
        cyc(24);
        check("t1_drop", dropped, REPEAT_BUILT);
        check("t1_hold_id", evt_id, 1);
        check("t1_hold_kind", evt_kind, EVT_PRESS);
        #2; rst_n = 1'b0; #1;
        check("t1_rst_valid", evt_valid, 0);
        check("t1_rst_level", level, 0);
        check("t1_rst_dropped", dropped, 0);
        check("t1_rst_id", evt_id, 0);
        btn_in = 4'b1010;
        @(posedge clk); #1;
        rst_n = 1'b1;
        evq.delete();
        wait_level(4'b1111, 4'b1010, 40, "t1_lvl2");
        cyc(2);
        check("t1_post_valid", evt_valid, 1);
        check("t1_ptr0", evt_id, 1);
        evt_ready = 1'b1;
        cyc(3);
        check("t1_ev0", evq[0].id, 1);
        check("t1_ev1", evq[1].id, 3);
        btn_in = 4'b0000;
        wait_level(4'b1010, 4'b0000, 40, "t1_rel");
        cyc(6);

        // All four pressed together, stalled, then drained back-to-back
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1; evt_ready = 1'b0; btn_in = 4'b1111;
        evq.delete();
        wait_level(4'b1111, 4'b1111, 40, "t5_lvl");
        cyc(2);
        check("t5_valid", evt_valid, 1);
        check("t5_first", evt_id, 0);
        cyc(3);
        check("t5_stable_id", evt_id, 0);
        check("t5_stable_kind", evt_kind, EVT_PRESS);
        evt_ready = 1'b1;
        cyc(6);
        for (int k = 0; k < 4; k++) begin
            check("t5_id", evq[k].id, k);
            check("t5_kind", evq[k].kind, EVT_PRESS);
            check("t5_b2b", evq[k].t - evq[0].t, k);
        end
        check("t5_drop", dropped, 0);
        btn_in = 4'b0000;
        wait_level(4'b1111, 4'b0000, 40, "t5_rel");
        cyc(6);
        check("t5_drop_end", dropped, 0);

        // Auto-repeat on btn1
        evq.delete();
        btn_in = 4'b0010;
        wait_level(4'b0010, 4'b0010, 40, "t4_lvl");
        cyc(40);
        btn_in = 4'b0000;
        wait_level(4'b0010, 4'b0000, 40, "t4_rel");
        cyc(30);
        nrep = count_ev(1, EVT_REPEAT);
        check("t4_other", evq.size() - count_ev(1, EVT_PRESS) - nrep - count_ev(1, EVT_RELEASE), 0);
        check("t4_press", evq[0].kind, EVT_PRESS);
        check("t4_nrep", REPEAT_BUILT ? (nrep >= 3) : (nrep == 0), 1);
        if (nrep >= 1) check("t4_hold_gap", evq[1].t - evq[0].t, 3 * SD);
        for (int k = 2; k <= nrep; k++) check("t4_rpt_gap", evq[k].t - evq[k-1].t, 2 * SD);
        check("t4_last", evq[last_idx()].kind, EVT_RELEASE);
        check("t4_size", evq.size(), nrep + 2);

        // Single press/release on btn0
        evq.delete();
        btn_in = 4'b0001;
        wait_level(4'b0001, 4'b0001, 2 * WIN_CYC + 3, "t2_lvl");
        cyc(3);
        check("t2_nev", evq.size(), 1);
        check("t2_id", evq[0].id, 0);
        check("t2_kind", evq[0].kind, EVT_PRESS);
        btn_in = 4'b0000;
        wait_level(4'b0001, 4'b0000, 40, "t2_fall");
        cyc(3);
        check("t2_press_cnt", count_ev(0, EVT_PRESS), 1);
        check("t2_rel_cnt", count_ev(0, EVT_RELEASE), 1);
        check("t2_last", evq[last_idx()].kind, EVT_RELEASE);
        n0 = evq.size();
        cyc(30);
        check("t2_quiet", evq.size(), n0);

        // Overflow of btn1 slot while stalled, then clr_drop
        evq.delete();
        evt_ready = 1'b0;
        btn_in = 4'b0010;
        wait_level(4'b0010, 4'b0010, 40, "t6_lvl");
        btn_in = 4'b0000;
        wait_level(4'b0010, 4'b0000, 40, "t6_fall");
        btn_in = 4'b0010;
        wait_level(4'b0010, 4'b0010, 40, "t6_lvl2");
        cyc(2);
        check("t6_drop", dropped, 1);
        check("t6_held_id", evt_id, 1);
        check("t6_held_kind", evt_kind, EVT_PRESS);
        clr_drop = 1'b1;
        cyc(1);
        clr_drop = 1'b0;
        check("t6_clr", dropped, 0);
        evt_ready = 1'b1;
        cyc(3);
        check("t6_ev0_id", evq[0].id, 1);
        check("t6_ev0_kind", evq[0].kind, EVT_PRESS);
        check("t6_ev1_id", evq[1].id, 1);
        check("t6_ev1_kind", evq[1].kind, REPEAT_BUILT ? EVT_REPEAT : EVT_RELEASE);
        btn_in = 4'b0000;
        wait_level(4'b0010, 4'b0000, 40, "t6_end");
        cyc(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_ctrl.md
# button_ctrl

Front-panel button controller for the function generator. It samples N raw push-buttons on a shared millisecond tick and majority-filters each one over a sample window. A per-button state machine produces press, release and auto-repeat events, and a round-robin arbiter serialises those events onto one valid/ready stream for the control FSM that steps frequency, amplitude and waveform.

## Interface
- `N_BTN`, 4: number of buttons, 1..16.
- `SAMPLE_DIV`, 50000: clock cycles per sample tick.
- `WINDOW`, 16: sample ticks per filter window, ≥2.
- `HOLD_TICKS`, 500: ticks a button must be held before auto-repeat starts.
- `REPEAT_TICKS`, 100: ticks between repeat events.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `btn_in`  in  N_BTN  raw asynchronous button levels, 1 = pressed.
- `enable`  in  1  run filter and timers.
- `evt_ready`  in  1  consumer accepts the current event.
- `clr_drop`  in  1  clears `dropped`.
- `level`  out  N_BTN  filtered button levels.
- `evt_valid`  out  1  an event is presented.
- `evt_id`  out  ID_W  button index. ID_W = max(1, clog2(N_BTN)).
- `evt_kind`  out  2  event kind: 0 = press, 1 = release, 2 = repeat.
- `dropped`  out  1  sticky flag: an event was lost.

## Operation
- **Synchroniser.** `btn_in` passes through 2 flops per bit before any use.
- **Prescaler.** Counts 0..SAMPLE_DIV-1 while `enable` is high. `tick` pulses for 1 cycle at the terminal count. When `enable` is low, the prescaler clears.
- **Filter, per button, on each tick.**
  - Increments the sample count and adds the synchronised bit to the ones count.
  - On the WINDOW-th sample: `level` ← (2·ones ≥ WINDOW), so a tie resolves to 1. Both counts then clear.
  - Count widths are clog2(WINDOW+1). No wrap is possible.
- **Per-button FSM** (states IDLE, PRESSED, REPEAT; hold counter advances on ticks only):
  - IDLE: `level` rises → PRESSED, counter ← 0, post press.
  - PRESSED: `level` falls → IDLE, post release. Counter reaches HOLD_TICKS → REPEAT, counter ← 0, post repeat.
  - REPEAT: `level` falls → IDLE, post release. Counter reaches REPEAT_TICKS → counter ← 0, post repeat.
  - A fall takes priority over a timer expiry on the same tick.
- **Pending slot.** One slot per button, holding a valid bit and the kind.
  - A post into an occupied slot is discarded and sets `dropped`.
  - Exception: if the slot is loaded into the output register in the same cycle as the post, the new event is captured and not counted as a drop.
- **Arbiter.** Round-robin pointer, reset value 0.
  - The output register loads when `evt_valid` is 0, or when `evt_valid`=1 and `evt_ready`=1.
  - It loads the first valid slot at or after the pointer, clears that slot, and sets pointer ← id+1 modulo N_BTN.
  - If no slot is valid, `evt_valid` drops to 0 after the handshake.
- **Handshake rules.**
  - While `evt_valid`=1 and `evt_ready`=0, `evt_id` and `evt_kind` are stable.
  - Back-to-back events are allowed at 1 per cycle.
- **`dropped`.** Cleared by `clr_drop`. If `clr_drop` and a drop occur in the same cycle, the set wins.
- **`enable` low.** Filter counts and FSM timers freeze, `level` holds, and pending events continue to drain.

## Timing
- **Reset values.** All outputs are 0. All FSMs are IDLE. All slots are empty.
- **Latency.**
  - `btn_in` → synchronised bit: 2 cycles.
  - A stable press reaches `level` within 2 windows.
  - FSM posts an event on the cycle `level` changes. `evt_valid` rises on the next cycle if the output register is free.
- **Mid-operation reset.** `rst_n` low returns every register to its reset value immediately, including a presented event. No handshake is completed.

## Configuration
- **`BTN_REPEAT_EN` defined:** REPEAT state, hold counter and repeat events are built as described above.
- **`BTN_REPEAT_EN` undefined:**
  - PRESSED is left only on release.
  - Kind 2 is never produced.
  - HOLD_TICKS and REPEAT_TICKS are ignored, and no hold counter is built.

## Structure
- **Package `btn_pkg`:**
  - FSM state constants IDLE=0, PRESSED=1, REPEAT=2.
  - Event kind constants EVT_PRESS=0, EVT_RELEASE=1, EVT_REPEAT=2.
- **Sub-module `btn_channel`:** instantiated N_BTN times. It contains the synchroniser, window filter, FSM, hold counter and pending slot.
- **Top level:** holds the prescaler, round-robin arbiter, output register and `dropped`.

## Test plan
Bench parameters: N_BTN=4, SAMPLE_DIV=4, WINDOW=4, HOLD_TICKS=3, REPEAT_TICKS=2, `BTN_REPEAT_EN` defined.
1. Pull `rst_n` low while `evt_valid`=1 → `evt_valid`, `level` and `dropped` are 0 immediately. After release, the first event starts from pointer 0.
2. Hold btn0 at 1 with `evt_ready`=1 → `level[0]` is 1 by the end of the 2nd window. Exactly one event id0/kind0 follows. Releasing gives one id0/kind1.
3. Btn2 samples 1,0,1,0 in a window → `level[2]`=1 (tie). Samples 1,0,0,0 from IDLE → no event.
4. Hold btn1 → press, then repeat 3 ticks later, then a repeat every 2 ticks. Releasing gives release and no further repeats.
5. Press btns 0-3 in the same window with `evt_ready`=0, then raise `evt_ready` → ids 0,1,2,3 on 4 consecutive cycles. `dropped` stays 0.
6. With `evt_ready`=0, press btn1 then release btn1 → release is discarded and `dropped`=1. `clr_drop` then returns `dropped` to 0.
